// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment pattern constants and capture FSM state type shared with the driver.
package seven_seg_pkg;
    localparam int DEF_FREQ = 250;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;
    typedef enum logic {WAIT_HI, WAIT_LO} seg_state_t;
endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: maps a gfedcba pattern back to its hex nibble; unknown patterns give 0 and bad=1.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] segment,
    output logic [3:0] nibble,
    output logic       bad
);
    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (segment)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
            default: bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: demultiplexes the driver's hi/lo digit strobes into decoded pairs,
// with a watchdog that drops lock when the strobe goes missing.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int FREQ  = DEF_FREQ,
    parameter int CBITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segment,
    input  logic       sig,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       pair_valid,
    output logic       bad_pattern,
    output logic       locked,
    output logic       timeout
);
    localparam logic [CBITS-1:0] WD_LAST = CBITS'(FREQ + 1);

    logic [3:0]       nib;
    logic             bad;
    seg_state_t       state_q;
    logic [3:0]       hold_q;
    logic             hold_bad_q;
    logic [CBITS-1:0] wd_q;
    logic             wd_hit;

    seven_seg_decode u_dec (.segment(segment), .nibble(nib), .bad(bad));

    // The (FREQ+2)th strobe-less cycle is the one that sees wd_q at FREQ+1.
    assign wd_hit = !sig && wd_q == WD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_HI;
            hold_q      <= 4'h0;
            hold_bad_q  <= 1'b0;
            wd_q        <= '0;
            digit_hi    <= 4'h0;
            digit_lo    <= 4'h0;
            pair_valid  <= 1'b0;
            bad_pattern <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            pair_valid <= 1'b0;
            timeout    <= 1'b0;
            if (sig) begin
                wd_q <= '0;
                if (state_q == WAIT_HI) begin
                    hold_q     <= nib;
                    hold_bad_q <= bad;
                    state_q    <= WAIT_LO;
                end else begin
                    digit_hi    <= hold_q;
                    digit_lo    <= nib;
                    bad_pattern <= hold_bad_q | bad;
                    pair_valid  <= 1'b1;
                    locked      <= 1'b1;
                    state_q     <= WAIT_HI;
                end
            end else if (wd_hit) begin
                timeout    <= 1'b1;
                locked     <= 1'b0;
                hold_q     <= 4'h0;
                hold_bad_q <= 1'b0;
                state_q    <= WAIT_HI;
                wd_q       <= '0;
            end else if (wd_q != '1) begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    a_lo_publishes: assert property (@(posedge clk) disable iff (rst)
        (sig && state_q == WAIT_LO) |=> pair_valid);
    a_timeout_excl: assert property (@(posedge clk) disable iff (rst)
        timeout |-> !pair_valid);
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: directed pair table plus hand sequences for timeout, reset and closed-loop cadence.
module tb_seven_seg_capture;
    import seven_seg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] segment = 7'h00;
    logic       sig = 1'b0;
    logic [3:0] digit_hi, digit_lo;
    logic       pair_valid, bad_pattern, locked, timeout;
    int tests = 0;
    int fails = 0;

    seven_seg_capture dut (
        .clk(clk), .rst(rst), .segment(segment), .sig(sig),
        .digit_hi(digit_hi), .digit_lo(digit_lo), .pair_valid(pair_valid),
        .bad_pattern(bad_pattern), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] hi_seg;
        logic [6:0] lo_seg;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       bad;
    } vec_t;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic st);
        segment = s;
        sig = st;
        @(posedge clk);
        #1;
        sig = 1'b0;
    endtask

    task automatic idle_until_timeout(output int n);
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            step(7'h00, 1'b0);
            if (timeout) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        vec_t v[10];
        int n, pairs, tos, last, gap_bad, dig_bad;
        logic saw_to;
        v[0] = '{SEG_0, SEG_1, 4'h0, 4'h1, 1'b0};
        v[1] = '{SEG_2, SEG_3, 4'h2, 4'h3, 1'b0};
        v[2] = '{SEG_4, SEG_5, 4'h4, 4'h5, 1'b0};
        v[3] = '{SEG_6, SEG_7, 4'h6, 4'h7, 1'b0};
        v[4] = '{SEG_8, SEG_9, 4'h8, 4'h9, 1'b0};
        v[5] = '{SEG_A, SEG_B, 4'hA, 4'hB, 1'b0};
        v[6] = '{SEG_C, SEG_D, 4'hC, 4'hD, 1'b0};
        v[7] = '{SEG_E, SEG_F, 4'hE, 4'hF, 1'b0};
        v[8] = '{7'h00, SEG_1, 4'h0, 4'h1, 1'b1};
        v[9] = '{SEG_F, 7'h7E, 4'hF, 4'h0, 1'b1};

        // reset values and first timeout
        rst = 1'b1;
        repeat (3) step(7'h00, 1'b0);
        rst = 1'b0;
        chk("rst_outputs", {digit_hi, digit_lo}, 8'h00);
        chk("rst_flags", {4'h0, pair_valid, bad_pattern, locked, timeout}, 8'h00);
        idle_until_timeout(n);
        chk("rst_timeout_cycle", 8'(n), 8'd252);
        step(7'h00, 1'b0);
        chk("timeout_one_cycle", {7'h0, timeout}, 8'h0);

        // normal pair at the maximum legal strobe gap
        step(SEG_3, 1'b1);
        saw_to = 1'b0;
        for (int i = 0; i < 250; i++) begin
            step(7'h00, 1'b0);
            saw_to |= timeout | pair_valid;
        end
        step(SEG_B, 1'b1);
        chk("gap251_quiet", {7'h0, saw_to}, 8'h0);
        chk("normal_digits", {digit_hi, digit_lo}, 8'h3B);
        chk("normal_flags", {4'h0, pair_valid, bad_pattern, locked, timeout}, 8'b1010);
        step(7'h00, 1'b0);
        chk("pv_one_cycle", {7'h0, pair_valid}, 8'h0);

        // table of pairs: all 16 digits, bad patterns, then a clean pair
        for (int k = 0; k < 10; k++) begin
            step(v[k].hi_seg, 1'b1);
            chk($sformatf("tbl%0d_no_pv_on_hi", k), {7'h0, pair_valid}, 8'h0);
            repeat (3) step(7'h00, 1'b0);
            step(v[k].lo_seg, 1'b1);
            chk($sformatf("tbl%0d_digits", k), {digit_hi, digit_lo}, {v[k].hi, v[k].lo});
            chk($sformatf("tbl%0d_flags", k), {5'h0, pair_valid, bad_pattern, locked},
                {5'h0, 1'b1, v[k].bad, 1'b1});
        end
        step(SEG_5, 1'b1);
        step(SEG_0, 1'b1);
        chk("bad_cleared", {3'h0, bad_pattern, digit_hi}, 8'h05);

        // lost lo strobe: timeout, digits kept, next strobe is hi
        step(SEG_9, 1'b1);
        idle_until_timeout(n);
        chk("lost_timeout_cycle", 8'(n), 8'd252);
        chk("lost_locked", {7'h0, locked}, 8'h0);
        chk("lost_digits_kept", {digit_hi, digit_lo}, 8'h50);
        step(SEG_2, 1'b1);
        chk("lost_next_is_hi", {7'h0, pair_valid}, 8'h0);
        step(SEG_7, 1'b1);
        chk("lost_next_pair", {digit_hi, digit_lo}, 8'h27);
        chk("lost_relock", {6'h0, pair_valid, locked}, 8'h3);

        // reset mid-pair with a coincident strobe
        step(SEG_9, 1'b1);
        rst = 1'b1;
        step(SEG_8, 1'b1);
        rst = 1'b0;
        chk("midrst_state", {digit_hi, digit_lo}, 8'h00);
        chk("midrst_flags", {6'h0, pair_valid, locked}, 8'h0);
        step(SEG_C, 1'b1);
        chk("midrst_hi_first", {7'h0, pair_valid}, 8'h0);
        step(SEG_D, 1'b1);
        chk("midrst_pair", {digit_hi, digit_lo}, 8'hCD);

        // closed loop against a behavioural driver: strobe every FREQ+1 cycles
        rst = 1'b1;
        step(7'h00, 1'b0);
        rst = 1'b0;
        pairs = 0; tos = 0; last = -1; gap_bad = 0; dig_bad = 0;
        for (int c = 0; c < 5000; c++) begin
            logic st;
            st = (c % 251) == 250;
            step(((c / 251) % 2 == 0) ? SEG_A : SEG_5, st);
            if (timeout) tos++;
            if (pair_valid) begin
                pairs++;
                if (last >= 0 && c - last != 502) gap_bad++;
                if ({digit_hi, digit_lo} != 8'hA5 || bad_pattern) dig_bad++;
                last = c;
            end
        end
        chk("loop_pairs", 8'(pairs), 8'd9);
        chk("loop_timeouts", 8'(tos), 8'd0);
        chk("loop_cadence_errs", 8'(gap_bad), 8'd0);
        chk("loop_digit_errs", 8'(dig_bad), 8'd0);
        chk("loop_locked", {7'h0, locked}, 8'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
